// File: rtl/approx_mult_error_profiler_if.sv
// Bus between the multiplier error profiler and its surroundings.
// It carries the operand outputs, the product inputs from the exact and
// approximate multipliers, the start/busy/done handshake and the final
// statistics.
//   slave  : profiler side (drives operands, handshake status, statistics)
//   master : environment side (drives start and both products)
interface approx_mult_error_profiler_if #(
  parameter int WIDTH = 8
) ();
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic [2*WIDTH-1:0]   prod_exact;
  logic [2*WIDTH-1:0]   prod_approx;
  logic [2*WIDTH:0]     err_count;
  logic [4*WIDTH-1:0]   sum_abs_err;
  logic [2*WIDTH-1:0]   max_abs_err;
  logic [WIDTH-1:0]     max_err_a;
  logic [WIDTH-1:0]     max_err_b;

  modport slave (
    input  start, prod_exact, prod_approx,
    output op_a, op_b, busy, done,
           err_count, sum_abs_err, max_abs_err, max_err_a, max_err_b
  );

  modport master (
    output start, prod_exact, prod_approx,
    input  op_a, op_b, busy, done,
           err_count, sum_abs_err, max_abs_err, max_err_a, max_err_b
  );
endinterface

// File: rtl/approx_mult_error_profiler.sv
// Exhaustive error profiler for a pair of multipliers (exact + approximate).
// Sweeps all 2^(2W) operand pairs, tracks each pair through a delay line
// that matches the multipliers' latency, and accumulates error statistics
// (nonzero-error count, sum of |error|, max |error| and its first operands).
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : profiler modport (start/busy/done, operands, products, stats)
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start after reset
// S_SWEEP | presenting one operand pair per cycle
// S_DRAIN | waiting L cycles for the last in-flight products
// S_DONE  | statistics final and held until the next start
module approx_mult_error_profiler #(
  parameter int WIDTH       = 8,
  parameter int DUT_LATENCY = 0
) (
  input  logic clk,
  input  logic rst_n,
  approx_mult_error_profiler_if.slave bus
);
  localparam int W = WIDTH;
  localparam int L = DUT_LATENCY;
  localparam logic [W-1:0]   OP_MAX     = '1;
  localparam logic [W-1:0]   OP_ONE     = 1;
  localparam logic [2*W:0]   CNT_ONE    = 1;
  localparam logic [2:0]     DRAIN_LOAD = 3'((L > 0) ? L - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [W-1:0]     op_a, op_b;
  logic [2:0]       drain_cnt;
  logic             last_pair;
  logic             start_ok;
  logic             smp_vld;
  logic [W-1:0]     smp_a, smp_b;
  logic [2*W-1:0]   diff;
  logic [2*W:0]     err_count;
  logic [4*W-1:0]   sum_abs_err;
  logic [2*W-1:0]   max_abs_err;
  logic [W-1:0]     max_err_a, max_err_b;

  assign start_ok  = bus.start && ((state == S_IDLE) || (state == S_DONE));
  assign last_pair = (op_a == OP_MAX) && (op_b == OP_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_SWEEP;
      S_SWEEP: if (last_pair) state_nxt = (L > 0) ? S_DRAIN : S_DONE;
      S_DRAIN: if (drain_cnt == 3'd0) state_nxt = S_DONE;
      S_DONE:  if (start_ok) state_nxt = S_SWEEP;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Drain timer: loaded with L-1 as the last pair leaves SWEEP, so DRAIN
  // spans exactly L cycles ending at terminal count 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt <= 3'd0;
    end else if ((state == S_SWEEP) && last_pair) begin
      drain_cnt <= DRAIN_LOAD;
    end else if ((state == S_DRAIN) && (drain_cnt != 3'd0)) begin
      drain_cnt <= drain_cnt - 3'd1;
    end
  end

  // op_a is the inner counter, op_b the outer one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a <= '0;
      op_b <= '0;
    end else if (start_ok) begin
      op_a <= '0;
      op_b <= '0;
    end else if (state == S_SWEEP) begin
      op_a <= op_a + OP_ONE;
      if (op_a == OP_MAX) op_b <= op_b + OP_ONE;
    end
  end

  // Issue tracking: the pair presented now returns from the multipliers
  // L cycles later, so its valid bit and operands travel alongside it.
  generate
    if (L == 0) begin : g_no_delay
      assign smp_vld = (state == S_SWEEP);
      assign smp_a   = op_a;
      assign smp_b   = op_b;
    end else begin : g_delay
      logic [L-1:0] vld_q;
      logic [W-1:0] a_q [L];
      logic [W-1:0] b_q [L];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= '0;
          for (int i = 0; i < L; i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
          end
        end else begin
          vld_q[0] <= (state == S_SWEEP) && !start_ok;
          a_q[0]   <= op_a;
          b_q[0]   <= op_b;
          for (int i = 1; i < L; i++) begin
            vld_q[i] <= start_ok ? 1'b0 : vld_q[i-1];
            a_q[i]   <= a_q[i-1];
            b_q[i]   <= b_q[i-1];
          end
        end
      end

      assign smp_vld = vld_q[L-1];
      assign smp_a   = a_q[L-1];
      assign smp_b   = b_q[L-1];
    end
  endgenerate

  // Unsigned ordered subtraction gives the same magnitude as a signed
  // 2W+1-bit difference, and it always fits in 2W bits.
  assign diff = (bus.prod_approx >= bus.prod_exact) ?
                (bus.prod_approx - bus.prod_exact) :
                (bus.prod_exact - bus.prod_approx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count   <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
      max_err_a   <= '0;
      max_err_b   <= '0;
    end else if (start_ok) begin
      err_count   <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
      max_err_a   <= '0;
      max_err_b   <= '0;
    end else if (smp_vld) begin
      if (diff != '0) err_count <= err_count + CNT_ONE;
      sum_abs_err <= sum_abs_err + {{(2*W){1'b0}}, diff};
      // Strictly greater: on a tie the earliest pair is kept.
      if (diff > max_abs_err) begin
        max_abs_err <= diff;
        max_err_a   <= smp_a;
        max_err_b   <= smp_b;
      end
    end
  end

  assign bus.op_a        = op_a;
  assign bus.op_b        = op_b;
  assign bus.busy        = (state == S_SWEEP) || (state == S_DRAIN);
  assign bus.done        = (state == S_DONE);
  assign bus.err_count   = err_count;
  assign bus.sum_abs_err = sum_abs_err;
  assign bus.max_abs_err = max_abs_err;
  assign bus.max_err_a   = max_err_a;
  assign bus.max_err_b   = max_err_b;
endmodule

// File: tb/tb_approx_mult_error_profiler.sv
module tb_approx_mult_error_profiler;
  localparam int W = 4;

  typedef struct {
    int     err_count;
    longint sum_abs;
    int     max_abs;
    int     max_a;
    int     max_b;
    int     done_cyc;
    int     e0;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] appx_tbl [16][16];
  logic [7:0] e1_q, e2_q, x1_q, x2_q;

  approx_mult_error_profiler_if #(.WIDTH(W)) bus0 ();
  approx_mult_error_profiler_if #(.WIDTH(W)) bus1 ();

  approx_mult_error_profiler #(.WIDTH(W), .DUT_LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  approx_mult_error_profiler #(.WIDTH(W), .DUT_LATENCY(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  // Latency-0 multipliers: exact product and a table-driven approximation.
  assign bus0.prod_exact  = 8'(bus0.op_a) * 8'(bus0.op_b);
  assign bus0.prod_approx = appx_tbl[bus0.op_a][bus0.op_b];

  // Latency-2 multipliers: both registered twice; approx clears bit 0.
  assign bus1.prod_exact  = e2_q;
  assign bus1.prod_approx = x2_q;
  initial begin
    forever begin
      @(posedge clk);
      e1_q <= 8'(bus1.op_a) * 8'(bus1.op_b);
      x1_q <= (8'(bus1.op_a) * 8'(bus1.op_b)) & 8'hFE;
      e2_q <= e1_q;
      x2_q <= x1_q;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_tbl(input int mode);
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        int ex;
        ex = a * b;
        case (mode)
          0: appx_tbl[a][b] = 8'(ex);
          1: appx_tbl[a][b] = 8'(ex + 1);
          2: appx_tbl[a][b] = ((a == 3 && b == 5) || (a == 9 && b == 2)) ? 8'(ex + 7) : 8'(ex);
          3: appx_tbl[a][b] = 8'd0;
          4: appx_tbl[a][b] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'(ex);
          default: appx_tbl[a][b] = 8'(ex & 32'hFE);
        endcase
      end
    end
  endtask

  // Reference: walk all pairs in sweep order using the table values.
  function automatic exp_t ref_model(input int lat, input int e0);
    exp_t r;
    r = '{default: 0};
    for (int b = 0; b < 16; b++) begin
      for (int a = 0; a < 16; a++) begin
        int ex, ap, d;
        ex = a * b;
        ap = int'(appx_tbl[a][b]);
        d  = (ap > ex) ? ap - ex : ex - ap;
        if (d != 0) r.err_count++;
        r.sum_abs += d;
        if (d > r.max_abs) begin
          r.max_abs = d;
          r.max_a   = a;
          r.max_b   = b;
        end
      end
    end
    r.done_cyc = 256 + lat + 1;
    r.e0       = e0;
    return r;
  endfunction

  task automatic start_dut(input int sel, input bit push, output int e0);
    @(negedge clk);
    e0 = cyc;
    if (sel == 0) begin
      if (push) q0.push_back(ref_model(0, e0));
      bus0.start = 1'b1;
    end else begin
      if (push) q1.push_back(ref_model(2, e0));
      bus1.start = 1'b1;
    end
    @(negedge clk);
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    if (sel == 0) begin
      chk("c1_busy", bus0.busy, 1);
      chk("c1_done", bus0.done, 0);
      chk("c1_err_count", bus0.err_count, 0);
      chk("c1_sum", bus0.sum_abs_err, 0);
    end else begin
      chk("c1_busy_l2", bus1.busy, 1);
      chk("c1_sum_l2", bus1.sum_abs_err, 0);
    end
  endtask

  task automatic wait_done(input int sel);
    int n;
    n = 0;
    while (((sel == 0) ? bus0.done : bus1.done) == 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done", n);
    end
  endtask

  task automatic run(input int sel);
    int e0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    start_dut(sel, 1'b1, e0);
    wait_done(sel);
  endtask

  task automatic compare(input string tag, input exp_t e, input longint ec, input longint sm,
                         input longint mx, input longint ma, input longint mb);
    chk({tag, "_done_cycle"}, cyc - e.e0, e.done_cyc);
    chk({tag, "_err_count"}, ec, e.err_count);
    chk({tag, "_sum_abs_err"}, sm, e.sum_abs);
    chk({tag, "_max_abs_err"}, mx, e.max_abs);
    chk({tag, "_max_err_a"}, ma, e.max_a);
    chk({tag, "_max_err_b"}, mb, e.max_b);
  endtask

  // Monitors: on each rising done, pop the expectation and compare.
  initial begin
    logic d_q;
    exp_t e;
    d_q = 1'b0;
    forever begin
      @(negedge clk);
      if (bus0.done && !d_q) begin
        if (q0.size() == 0) begin
          chk("dut0_unexpected_done", 1, 0);
        end else begin
          e = q0.pop_front();
          compare("dut0", e, bus0.err_count, bus0.sum_abs_err, bus0.max_abs_err,
                  bus0.max_err_a, bus0.max_err_b);
        end
      end
      d_q = bus0.done;
    end
  end

  initial begin
    logic d_q;
    exp_t e;
    d_q = 1'b0;
    forever begin
      @(negedge clk);
      if (bus1.done && !d_q) begin
        if (q1.size() == 0) begin
          chk("dut1_unexpected_done", 1, 0);
        end else begin
          e = q1.pop_front();
          compare("dut1", e, bus1.err_count, bus1.sum_abs_err, bus1.max_abs_err,
                  bus1.max_err_a, bus1.max_err_b);
        end
      end
      d_q = bus1.done;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    fill_tbl(0);
    repeat (3) @(negedge clk);
    chk("rst_busy", bus0.busy, 0);
    chk("rst_done", bus0.done, 0);
    chk("rst_op_a", bus0.op_a, 0);
    chk("rst_err_count", bus0.err_count, 0);
    chk("rst_max_abs_err", bus0.max_abs_err, 0);
    chk("rst_busy_l2", bus1.busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    fill_tbl(0); run(0);
    fill_tbl(1); run(0);
    fill_tbl(2); run(0);
    fill_tbl(3); run(0);
    fill_tbl(4); run(0);
    fill_tbl(4); run(0);

    // Starts mid-sweep must be ignored without disturbing timing.
    fill_tbl(0);
    start_dut(0, 1'b1, e0);
    while (cyc < e0 + 10) @(negedge clk);
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    while (cyc < e0 + 100) @(negedge clk);
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    wait_done(0);

    // Abort by reset partway through a sweep with nonzero statistics.
    fill_tbl(3);
    start_dut(0, 1'b0, e0);
    while (cyc < e0 + 120) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", bus0.busy, 0);
    chk("abort_done", bus0.done, 0);
    chk("abort_op_a", bus0.op_a, 0);
    chk("abort_op_b", bus0.op_b, 0);
    chk("abort_err_count", bus0.err_count, 0);
    chk("abort_sum", bus0.sum_abs_err, 0);
    chk("abort_max", bus0.max_abs_err, 0);
    chk("abort_max_a", bus0.max_err_a, 0);
    chk("abort_max_b", bus0.max_err_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_abort_busy", bus0.busy, 0);
    chk("post_abort_done", bus0.done, 0);
    fill_tbl(0); run(0);

    // Latency-2 pipeline.
    fill_tbl(5); run(1);

    repeat (5) @(negedge clk);
    chk("dut0_pending_expectations", q0.size(), 0);
    chk("dut1_pending_expectations", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
